// File: rtl/ts_packet_monitor_pkg.sv
// Shared constants and lock-state encoding for the transport-stream packet monitor.
package ts_packet_monitor_pkg;

  localparam logic [7:0]  SYNC_BYTE       = 8'h47;
  localparam logic [12:0] NULL_PID        = 13'h1FFF;
  localparam int          PKT_LEN_DEFAULT = 188;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/ts_packet_monitor_if.sv
// Byte-stream input bundle: one byte accepted per clock while ts_valid is high, no backpressure.
interface ts_packet_monitor_if;

  logic [7:0] ts_data;
  logic       ts_valid;

  modport master (output ts_data, output ts_valid);
  modport slave  (input  ts_data, input  ts_valid);

endinterface

// File: rtl/ts_packet_monitor_sync_fsm.sv
// Sync-byte hunter: tracks packet alignment and reports byte position, lock state and missed syncs.
//   state  | meaning
//   HUNT   | scanning every accepted byte for 0x47
//   VERIFY | candidate alignment, counting correctly spaced syncs
//   LOCKED | aligned; missed syncs counted toward losing lock
module ts_sync_fsm
  import ts_packet_monitor_pkg::*;
#(
  parameter int PKT_LEN      = PKT_LEN_DEFAULT,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 ts_data,
  input  logic                       ts_valid,
  output logic [$clog2(PKT_LEN)-1:0] byte_pos,
  output logic [1:0]                 lock_state,
  output logic                       sync,
  output logic                       miss_evt
);

  localparam int            PW       = $clog2(PKT_LEN);
  localparam logic [PW-1:0] LAST_POS = PW'(PKT_LEN - 1);
  localparam logic [7:0]    LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]    UNLOCK_N = 8'(UNLOCK_COUNT);

  lock_state_e   state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [7:0]    hits_q, hits_d;
  logic [7:0]    miss_q, miss_d;
  logic          sync_q, sync_d;
  logic          is_sync;

  assign is_sync = (ts_data == SYNC_BYTE);

  // pos_q holds the position of the next byte to be accepted
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    sync_d   = 1'b0;
    miss_evt = 1'b0;
    if (ts_valid) begin
      pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            pos_d  = PW'(1);
            hits_d = 8'd1;
            if (LOCK_N <= 8'd1) begin
              state_d = LOCKED;
              sync_d  = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end else begin
            pos_d = '0;
          end
        end
        VERIFY: begin
          if (pos_q == '0) begin
            if (is_sync) begin
              hits_d = hits_q + 8'd1;
              if (hits_q + 8'd1 >= LOCK_N) begin
                state_d = LOCKED;
                sync_d  = 1'b1;
              end
            end else begin
              state_d = HUNT;
              hits_d  = 8'd0;
              pos_d   = '0;
            end
          end
        end
        LOCKED: begin
          if (pos_q == '0) begin
            if (is_sync) begin
              miss_d = 8'd0;
              sync_d = 1'b1;
            end else begin
              miss_evt = 1'b1;
              miss_d   = miss_q + 8'd1;
              if (miss_q + 8'd1 >= UNLOCK_N) begin
                state_d = HUNT;
                miss_d  = 8'd0;
                hits_d  = 8'd0;
                pos_d   = '0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      pos_q   <= '0;
      hits_q  <= 8'd0;
      miss_q  <= 8'd0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      sync_q  <= sync_d;
    end
  end

  assign byte_pos   = pos_q;
  assign lock_state = state_q;
  assign sync       = sync_q;

endmodule

// File: rtl/ts_packet_monitor.sv
// Transport-stream monitor: sync lock via ts_sync_fsm, plus header capture, TEI/CC checks and error counting.
module ts_packet_monitor
  import ts_packet_monitor_pkg::*;
#(
  parameter int PKT_LEN      = PKT_LEN_DEFAULT,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  ts_packet_monitor_if.slave  ts_if,
  input  logic [12:0]         mon_pid,
  input  logic                clear_count,
  output logic                sync,
  output logic                valid,
  output logic [7:0]          err_count,
  output logic [1:0]          lock_state
);

  localparam int            PW     = $clog2(PKT_LEN);
  localparam logic [PW-1:0] POS_B1 = PW'(1);
  localparam logic [PW-1:0] POS_B2 = PW'(2);
  localparam logic [PW-1:0] POS_B3 = PW'(3);

  logic [PW-1:0] byte_pos;
  logic [1:0]    lock_st;
  logic          miss_evt;

  ts_sync_fsm #(
    .PKT_LEN      (PKT_LEN),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_sync_fsm (
    .clk        (clk),
    .rst        (rst),
    .ts_data    (ts_if.ts_data),
    .ts_valid   (ts_if.ts_valid),
    .byte_pos   (byte_pos),
    .lock_state (lock_st),
    .sync       (sync),
    .miss_evt   (miss_evt)
  );

  logic [4:0]  pid_hi_q, pid_hi_d;
  logic [7:0]  pid_lo_q, pid_lo_d;
  logic [3:0]  last_cc_q, last_cc_d;
  logic        cc_valid_q, cc_valid_d;
  logic        dup_q, dup_d;
  logic [12:0] mon_pid_q;
  logic [7:0]  err_q, err_d;
  logic        locked, hdr_byte, pid_match, tei_evt, cc_err, inc;
  logic [3:0]  cc_rx;

  assign locked    = (lock_st == LOCKED);
  assign hdr_byte  = ts_if.ts_valid && locked;
  assign cc_rx     = ts_if.ts_data[3:0];
  assign pid_match = ({pid_hi_q, pid_lo_q} == mon_pid) && (mon_pid != NULL_PID);

  always_comb begin
    pid_hi_d   = pid_hi_q;
    pid_lo_d   = pid_lo_q;
    last_cc_d  = last_cc_q;
    cc_valid_d = cc_valid_q;
    dup_d      = dup_q;
    tei_evt    = 1'b0;
    cc_err     = 1'b0;
    if (hdr_byte && byte_pos == POS_B1) begin
      tei_evt  = ts_if.ts_data[7];
      pid_hi_d = ts_if.ts_data[4:0];
    end
    if (hdr_byte && byte_pos == POS_B2) pid_lo_d = ts_if.ts_data;
    // AFC bit 4 alone says whether a payload is present, so it selects the CC rule
    if (hdr_byte && byte_pos == POS_B3 && pid_match) begin
      dup_d = 1'b0;
      if (cc_valid_q) begin
        if (ts_if.ts_data[4]) begin
          if (cc_rx == last_cc_q + 4'd1) begin
            dup_d = 1'b0;
          end else if (cc_rx == last_cc_q) begin
            cc_err = dup_q;
            dup_d  = 1'b1;
          end else begin
            cc_err = 1'b1;
          end
        end else begin
          cc_err = (cc_rx != last_cc_q);
        end
      end
      last_cc_d  = cc_rx;
      cc_valid_d = 1'b1;
    end
    if (!locked || mon_pid != mon_pid_q || clear_count) begin
      cc_valid_d = 1'b0;
      dup_d      = 1'b0;
    end
  end

  // TEI, CC and miss events sit on different byte positions, so at most one fires per cycle
  assign inc = miss_evt | tei_evt | cc_err;

  always_comb begin
    err_d = err_q;
    if (clear_count)                err_d = {7'd0, inc};
    else if (inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_hi_q   <= '0;
      pid_lo_q   <= '0;
      last_cc_q  <= '0;
      cc_valid_q <= 1'b0;
      dup_q      <= 1'b0;
      mon_pid_q  <= NULL_PID;
      err_q      <= '0;
    end else begin
      pid_hi_q   <= pid_hi_d;
      pid_lo_q   <= pid_lo_d;
      last_cc_q  <= last_cc_d;
      cc_valid_q <= cc_valid_d;
      dup_q      <= dup_d;
      mon_pid_q  <= mon_pid;
      err_q      <= err_d;
    end
  end

  assign valid      = locked;
  assign err_count  = err_q;
  assign lock_state = lock_st;

endmodule

// File: tb/tb_ts_packet_monitor.sv
// Scoreboarded bench for ts_packet_monitor: packet-level reference model, sync-pulse monitor, phase checks.
module tb_ts_packet_monitor;
  import ts_packet_monitor_pkg::*;

  localparam int PLEN     = 188;
  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] mon_pid = 13'h1FFF;
  logic        clear_count = 1'b0;
  logic        sync, valid;
  logic [7:0]  err_count;
  logic [1:0]  lock_state;

  ts_packet_monitor_if ts_if ();

  ts_packet_monitor #(
    .PKT_LEN      (PLEN),
    .LOCK_COUNT   (LOCK_N),
    .UNLOCK_COUNT (UNLOCK_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ts_if       (ts_if),
    .mon_pid     (mon_pid),
    .clear_count (clear_count),
    .sync        (sync),
    .valid       (valid),
    .err_count   (err_count),
    .lock_state  (lock_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit gapped = 0;

  // packet-level reference: 0 hunt, 1 verify, 2 locked
  int m_st, m_hits, m_miss, m_err, m_last;
  bit m_ccv, m_dup;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_hits = 0; m_miss = 0; m_err = 0; m_last = 0; m_ccv = 0; m_dup = 0;
    exp_q.delete();
  endtask

  task automatic model_pkt(input bit ok, input bit tei, input int pid, input int afc,
                           input int cc, input bit clr);
    case (m_st)
      0: if (ok) begin m_st = 1; m_hits = 1; end
      1: if (ok) begin
           m_hits++;
           if (m_hits == LOCK_N) begin m_st = 2; exp_q.push_back(m_err); end
         end else m_st = 0;
      default: if (ok) begin
           m_miss = 0;
           exp_q.push_back(m_err);
         end else begin
           m_miss++;
           m_err = sat(m_err + 1);
           if (m_miss == UNLOCK_N) begin m_st = 0; m_miss = 0; m_ccv = 0; end
         end
    endcase
    if (clr) begin
      m_err = (m_st == 2 && tei) ? 1 : 0;
      m_ccv = 0;
    end else if (m_st == 2 && tei) m_err = sat(m_err + 1);
    if (m_st == 2 && pid == int'(mon_pid) && mon_pid != 13'h1FFF) begin
      if (m_ccv) begin
        if (afc % 2 == 1) begin
          if (cc == (m_last + 1) % 16) m_dup = 0;
          else if (cc == m_last) begin
            if (m_dup) m_err = sat(m_err + 1);
            m_dup = 1;
          end else begin
            m_err = sat(m_err + 1);
            m_dup = 0;
          end
        end else begin
          if (cc != m_last) m_err = sat(m_err + 1);
          m_dup = 0;
        end
      end else m_dup = 0;
      m_last = cc;
      m_ccv  = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit clr);
    if (gapped) begin
      while ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        ts_if.ts_valid = 1'b0;
        ts_if.ts_data  = 8'($urandom);
        clear_count    = 1'b0;
      end
    end
    @(posedge clk); #1;
    ts_if.ts_valid = 1'b1;
    ts_if.ts_data  = d;
    clear_count    = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ts_if.ts_valid = 1'b0;
      clear_count    = 1'b0;
    end
  endtask

  task automatic send_pkt(input bit ok, input bit tei, input int pid, input int afc,
                          input int cc, input bit clr);
    logic [7:0]  b;
    logic [12:0] p;
    logic [1:0]  a;
    logic [3:0]  c;
    p = 13'(pid); a = 2'(afc); c = 4'(cc);
    model_pkt(ok, tei, pid, afc, cc, clr);
    b = 8'($urandom);
    if (b == 8'h47) b = 8'h48;
    send_byte(ok ? 8'h47 : b, 1'b0);
    send_byte({tei, 2'b00, p[12:8]}, clr);
    send_byte(p[7:0], 1'b0);
    send_byte({2'b00, a, c}, 1'b0);
    for (int i = 4; i < PLEN; i++) begin
      b = 8'($urandom);
      if (b == 8'h47) b = 8'h00;
      send_byte(b, 1'b0);
    end
  endtask

  task automatic set_mon_pid(input logic [12:0] p);
    idle(2);
    mon_pid = p;
    m_ccv   = 0;
    idle(1);
  endtask

  // monitor: every sync pulse consumes one predicted entry
  always @(negedge clk) begin
    if (rst === 1'b0 && sync === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sync: got pulse expected none at %0t", $time);
      end else begin
        check("sync_err_count", int'(err_count), exp_q.pop_front());
        check("sync_lock_state", int'(lock_state), 2);
        check("sync_valid", int'(valid), 1);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cc_gen, pid, r, afc;
    int pids[3] = '{32'h100, 32'h101, 32'h200};
    ts_if.ts_valid = 1'b0;
    ts_if.ts_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_lock", int'(lock_state), 0);
    check("rst_err", int'(err_count), 0);
    rst = 1'b0;
    idle(2);
    check("post_rst_valid", int'(valid), 0);
    check("post_rst_err", int'(err_count), 0);

    // lock on clean packets
    for (int i = 0; i < 5; i++) send_pkt(1, 0, 'h200, 1, i, 0);
    idle(2);
    check("lock_state", int'(lock_state), 2);
    check("lock_err", int'(err_count), 0);

    // three missed syncs drop lock
    for (int i = 0; i < 3; i++) send_pkt(0, 0, 'h200, 1, i, 0);
    idle(2);
    check("unlock_err", int'(err_count), 3);
    check("unlock_lock", int'(lock_state), 0);
    check("unlock_valid", int'(valid), 0);

    // relock, then CC 5,6,6,6,8 on the monitored PID
    for (int i = 0; i < 3; i++) send_pkt(1, 0, 'h200, 1, 0, 0);
    set_mon_pid(13'h100);
    send_pkt(1, 0, 'h100, 1, 5, 0);
    send_pkt(1, 0, 'h100, 1, 6, 0);
    send_pkt(1, 0, 'h100, 1, 6, 0);
    send_pkt(1, 0, 'h100, 1, 6, 0);
    send_pkt(1, 0, 'h100, 1, 8, 0);
    idle(2);
    check("cc_err", int'(err_count), 5);
    check("cc_err_model", int'(err_count), m_err);

    // randomized, gapped traffic
    gapped = 1;
    cc_gen = 0;
    for (int i = 0; i < 25; i++) begin
      r   = $urandom_range(0, 9);
      pid = pids[$urandom_range(0, 2)];
      afc = $urandom_range(0, 3);
      if (r < 6) cc_gen = (cc_gen + 1) % 16;
      else if (r < 8) cc_gen = cc_gen;
      else cc_gen = $urandom_range(0, 15);
      send_pkt($urandom_range(0, 11) != 0, $urandom_range(0, 9) == 0, pid, afc, cc_gen, 0);
    end
    idle(2);
    check("rand_err", int'(err_count), m_err);
    check("rand_lock", int'(lock_state), m_st);

    // clear alone, then a clean gapped stream
    @(posedge clk); #1;
    ts_if.ts_valid = 1'b0;
    clear_count    = 1'b1;
    m_err = 0; m_ccv = 0;
    idle(2);
    check("clear_alone", int'(err_count), 0);
    for (int i = 0; i < 15; i++) send_pkt(1, 0, 'h100, 1, i % 16, 0);
    idle(2);
    gapped = 0;
    check("gap_lock", int'(lock_state), 2);
    check("gap_err", int'(err_count), 0);

    // TEI saturation, then clear coinciding with an increment
    for (int i = 0; i < 300; i++) send_pkt(1, 1, 'h200, 0, 0, 0);
    idle(2);
    check("sat_err", int'(err_count), 255);
    send_pkt(1, 1, 'h200, 0, 0, 1);
    idle(2);
    check("clear_with_inc", int'(err_count), 1);
    check("clear_with_inc_model", int'(err_count), m_err);

    // reset in the middle of a packet
    model_pkt(1, 0, 'h200, 0, 0, 0);
    send_byte(8'h47, 0);
    for (int i = 1; i < 60; i++) send_byte(8'h10, 0);
    #3 rst = 1'b1;
    #2;
    check("mid_rst_lock", int'(lock_state), 0);
    check("mid_rst_err", int'(err_count), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_sync", int'(sync), 0);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 2; i++) send_pkt(1, 0, 'h200, 0, 0, 0);
    idle(2);
    check("relock_pending", int'(lock_state), 1);
    send_pkt(1, 0, 'h200, 0, 0, 0);
    idle(2);
    check("relock_lock", int'(lock_state), 2);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_packet_monitor.md
TS_PACKET_MONITOR -- requirements
Module: ts_packet_monitor

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188, meaning the transport packet length in bytes.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, meaning the number of consecutive correctly spaced sync bytes required to lock.
REQ-003 SHALL have parameter UNLOCK_COUNT, default 3, meaning the number of consecutive missed sync bytes that drops lock.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ts_data, input, 8 bits: transport-stream byte.
REQ-007 SHALL have port ts_valid, input, 1 bit: ts_data is accepted on every clk edge where ts_valid=1; no backpressure.
REQ-008 SHALL have port mon_pid, input, 13 bits: PID monitored for continuity errors; 0x1FFF disables CC checking.
REQ-009 SHALL have port clear_count, input, 1 bit: one-cycle request to clear err_count; driven by the channel selector's en_reset_counter.
REQ-010 SHALL have port sync, output, 1 bit: one-cycle pulse per sync byte accepted in LOCKED.
REQ-011 SHALL have port valid, output, 1 bit: level, 1 while in LOCKED.
REQ-012 SHALL have port err_count, output, 8 bits: saturating error counter; one slice of the selector's 32-bit err_count.
REQ-013 SHALL have port lock_state, output, 2 bits: HUNT=0, VERIFY=1, LOCKED=2.

Function
REQ-014 SHALL implement the FSM states HUNT, VERIFY and LOCKED; bytes are counted only on accepted bytes, never on idle cycles.
REQ-015 In HUNT, an accepted 0x47 SHALL set byte_pos=0, set hits=1 and move to VERIFY; any other byte SHALL leave the state unchanged.
REQ-016 byte_pos SHALL increment on each accepted byte and wrap from PKT_LEN-1 to 0.
REQ-017 In VERIFY, if the byte at byte_pos=0 is 0x47 the FSM SHALL increment hits, otherwise it SHALL return to HUNT; when hits reaches LOCK_COUNT it SHALL move to LOCKED.
REQ-018 In LOCKED, if the byte at byte_pos=0 is not 0x47 the FSM SHALL increment miss_cnt and err_count; if it is 0x47 it SHALL clear miss_cnt.
REQ-019 When miss_cnt reaches UNLOCK_COUNT the FSM SHALL move to HUNT; the byte causing the transition is not re-examined as a sync candidate.
REQ-020 sync SHALL pulse in the cycle after an accepted 0x47 at byte_pos=0 in LOCKED, including the sync byte that completes VERIFY to LOCKED.
REQ-021 Header capture in LOCKED: TEI = byte1[7]; PID = {byte1[4:0], byte2}; AFC = byte3[5:4]; CC = byte3[3:0].
REQ-022 TEI=1 SHALL increment err_count by 1, registered in the cycle after byte1.
REQ-023 CC checking SHALL apply only when PID==mon_pid, mon_pid!=0x1FFF and the last-CC register is valid.
REQ-024 CC rule with AFC=01 or 11: CC==last+1 mod 16 is OK; CC==last is a duplicate, OK once, and a second consecutive duplicate is an error.
REQ-025 CC rule with AFC=00 or 10: CC must equal last.
REQ-026 A CC violation SHALL increment err_count in the cycle after byte3; the last-CC register SHALL always be updated with the received CC.
REQ-027 The last-CC valid flag SHALL be cleared on leaving LOCKED, on any change of mon_pid, and on clear_count.
REQ-028 err_count SHALL saturate at 0xFF and never wrap.
REQ-029 When clear_count coincides with an increment, the next value SHALL be 1; clear_count alone SHALL give 0.
REQ-030 At most one increment per cycle SHALL be possible, because TEI, CC and miss events fall on distinct byte positions.

Reset
REQ-031 On rst=1, asynchronously: state=HUNT, byte_pos=0, hits=0, miss_cnt=0, last-CC invalid, sync=0, valid=0, err_count=0, lock_state=0.
REQ-032 rst asserted mid-packet SHALL discard all partial header state; after release, the block SHALL relock only after LOCK_COUNT fresh syncs.

Structure
REQ-033 The shared package SHALL hold the constants SYNC_BYTE=0x47, NULL_PID=0x1FFF, PKT_LEN default and the lock_state encodings.
REQ-034 The sync FSM SHALL be split into a sub-module ts_sync_fsm (outputs byte_pos, lock_state, sync, miss event); the header/CC/counter logic SHALL stay in the top module.
REQ-035 Four instances SHALL be used per system, one per channel; their sync, valid and err_count outputs concatenate with channel 0 in the LSBs.

Verification
REQ-036 Reset state: after rst, verify valid=0, lock_state=0 and err_count=0.
REQ-037 Lock: 3 clean 188-byte packets, 0x47 at each packet start -> lock_state=2 after the 3rd sync; sync pulses on the 3rd sync and every later one.
REQ-038 Unlock: 3 corrupted sync bytes in LOCKED -> err_count=3, lock_state=0.
REQ-039 CC sequence on mon_pid=0x100, AFC=01: CC 5,6,6,6,8 -> err_count=2 (second duplicate, then the jump).
REQ-040 Saturation and clear: 300 TEI packets -> err_count=0xFF; clear_count coinciding with a TEI increment -> 1.
REQ-041 Gapped input: ts_valid toggled randomly across a clean stream -> lock held and err_count=0.
